msu_sd_arbiter: RTL and testbench
=================================

Name: msu_sd_arbiter

Overview:
Shares the single MSU SD-card sector channel (`sd_lba`/`sd_rd`/`sd_ack`/`sd_buff_wr`) between two requesters: the audio streamer (ch0) and the MSU data-port streamer (ch1). It sits between both streamers and the HPS SD interface. It latches each requester's LBA and issues one sector read at a time. It routes `ack` and `buff_wr` back only to the granted channel, and guards against HPS stalls with a timeout.

Parameters:
- SECTOR_WORDS, 256, 16-bit words per sector; an ack-low with a different count is a short transfer.
- TIMEOUT_CYCLES, 1048576, cycles allowed from `sd_rd` assertion to `sd_ack` rising.
- STARVE_LIMIT, 4, maximum consecutive ch1 grants while ch0 is pending.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rd0  in  1  ch0 (audio) sector request, level, held until ack0 seen
- lba0  in  21  ch0 sector address, stable while rd0 high
- urgent0  in  1  audio FIFO low; ch0 wins next arbitration unconditionally
- rd1  in  1  ch1 (data) sector request
- lba1  in  21  ch1 sector address
- ack0  out  1  `sd_ack` gated to ch0
- ack1  out  1  `sd_ack` gated to ch1
- wr0  out  1  `sd_buff_wr` gated to ch0
- wr1  out  1  `sd_buff_wr` gated to ch1
- sd_lba  out  21  registered LBA to HPS
- sd_rd  out  1  read request to HPS
- sd_ack  in  1  HPS transfer acknowledge, high for the whole sector
- sd_buff_wr  in  1  HPS word strobe
- grant  out  2  one-hot current owner; 00 when idle
- timeout_err  out  1  one-cycle pulse on timeout
- short_err  out  1  one-cycle pulse on short transfer

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs 0. Internal counters and streak count 0. `sd_lba`=0.
- States: IDLE, ISSUE, XFER, GAP.

IDLE:
- Arbitrate among pending rd0/rd1. Priority order:
  1. urgent0 && rd0 → ch0.
  2. streak>=STARVE_LIMIT && rd0 → ch0.
  3. rd1 → ch1.
  4. rd0 → ch0.
- On a grant: latch lbaN into `sd_lba`, set `grant`, `sd_rd`=1 next cycle, clear timeout counter, go to ISSUE.
- Streak: increments on a ch1 grant made while rd0 is high; clears on any ch0 grant; saturates at STARVE_LIMIT.

ISSUE:
- `sd_rd` held high. Timeout counter increments each cycle.
- `sd_ack` rises → `sd_rd`=0 (registered, 1-cycle latency), word counter=0, go to XFER.
- Counter reaches TIMEOUT_CYCLES-1 with no ack → `sd_rd`=0, `timeout_err` pulse, go to GAP. Requester is not acked and must re-request.

XFER:
- ackN = `sd_ack` and wrN = `sd_buff_wr`, combinational, only for the granted channel; the other channel sees 0.
- Word counter increments on each `sd_buff_wr`, saturating at 511.
- `sd_ack` falls → if count != SECTOR_WORDS, pulse `short_err`; go to GAP.

GAP:
- One cycle. `grant`=00. Then IDLE.
- Guarantees at least 1 idle cycle between sectors, so a requester sees ack low before any re-grant.

Rules:
- `sd_ack` high while in IDLE or GAP (stray ack) is ignored and not forwarded.
- rdN dropping mid-ISSUE/XFER does not abort; the sector completes and data is still strobed.
- rd0 and rd1 rising in the same cycle resolve by the priority order above.
- lbaN changes after grant are ignored (LBA is latched).
- Async reset mid-XFER: `sd_rd`, `grant`, and ack/wr gating all drop immediately.

Optional Feature:
- Macro MSU_ARB_STATS_EN.
- When defined: adds outputs `sectors0` and `sectors1` (16 bits each), counting completed XFERs per channel, wrapping at 0xFFFF. Also adds `timeouts` (8 bits, saturating). All reset to 0.
- When undefined: these ports and counters are absent, with no other behaviour change.

Test Plan:
- rd0=1, lba0=0x00010: `sd_rd` high 1 cycle after grant; HPS acks and sends 256 wr → wr0 pulses 256, wr1 stays 0, no `short_err`, `grant` 01→00, IDLE after the GAP cycle.
- rd0 and rd1 asserted together, urgent0=0 → ch1 served first, `sd_lba`=lba1; then ch0 follows. Same with urgent0=1 → ch0 first.
- rd0 held, rd1 re-asserted continuously, STARVE_LIMIT=4 → 4 ch1 sectors, then ch0 granted as the 5th.
- TIMEOUT_CYCLES=16, no `sd_ack` → `sd_rd` drops after 16 cycles, `timeout_err` pulses once, `grant`=00; ack0 never asserts.
- HPS sends 200 wr then drops ack → `short_err` pulse at ack fall; next request is granted normally.
- reset driven low mid-XFER (word 100) → `sd_rd`=0, `grant`=00, wr0 gated immediately. After release, a new rd0 gets a clean sector.

Source files
------------

// File: rtl/msu_sd_arbiter_if.sv
// Bundle of the requester-side and HPS-side signals of the MSU SD sector arbiter.
// slave  : arbiter view (requests and HPS responses in, grants/forwarded strobes out).
// master : environment view (requesters plus HPS model).
// Optional MSU_ARB_STATS_EN adds sectors0/sectors1/timeouts statistic outputs.
interface msu_sd_arbiter_if;
    localparam int unsigned LBA_W = 21;

    logic             rd0;
    logic [LBA_W-1:0] lba0;
    logic             urgent0;
    logic             rd1;
    logic [LBA_W-1:0] lba1;
    logic             ack0;
    logic             ack1;
    logic             wr0;
    logic             wr1;
    logic [LBA_W-1:0] sd_lba;
    logic             sd_rd;
    logic             sd_ack;
    logic             sd_buff_wr;
    logic [1:0]       grant;
    logic             timeout_err;
    logic             short_err;
`ifdef MSU_ARB_STATS_EN
    logic [15:0]      sectors0;
    logic [15:0]      sectors1;
    logic [7:0]       timeouts;
`endif

    modport slave (
        input  rd0, lba0, urgent0, rd1, lba1, sd_ack, sd_buff_wr,
`ifdef MSU_ARB_STATS_EN
        output sectors0, sectors1, timeouts,
`endif
        output ack0, ack1, wr0, wr1, sd_lba, sd_rd, grant, timeout_err, short_err
    );

    modport master (
        output rd0, lba0, urgent0, rd1, lba1, sd_ack, sd_buff_wr,
`ifdef MSU_ARB_STATS_EN
        input  sectors0, sectors1, timeouts,
`endif
        input  ack0, ack1, wr0, wr1, sd_lba, sd_rd, grant, timeout_err, short_err
    );
endinterface

// File: rtl/msu_sd_arbiter.sv
// Two-requester arbiter for the MSU SD-card sector channel (ch0 audio, ch1 data port).
// Ports: clk, reset (async active-low), bus (msu_sd_arbiter_if.slave).
// One sector read in flight at a time; ack/buff_wr forwarded only to the owner;
// ISSUE stall guarded by a timeout; ch1 streak bounded so ch0 cannot starve.
// Optional macro MSU_ARB_STATS_EN: per-channel completed-sector and timeout counters.
module msu_sd_arbiter #(
    parameter int unsigned SECTOR_WORDS   = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic               clk,
    input  logic               reset,
    msu_sd_arbiter_if.slave    bus
);
    localparam int unsigned LBA_W = 21;
    localparam int unsigned WC_W  = 9;
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned ST_W  = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, GAP} state_t;

    state_t           state, state_d;
    logic [LBA_W-1:0] sd_lba_q, sd_lba_d;
    logic             sd_rd_q, sd_rd_d;
    logic [1:0]       grant_q, grant_d;
    logic             terr_q, terr_d;
    logic             serr_q, serr_d;
    logic [TO_W-1:0]  to_cnt, to_cnt_d;
    logic [WC_W-1:0]  wcnt, wcnt_d;
    logic [ST_W-1:0]  streak, streak_d;
    logic             take0, take1;
`ifdef MSU_ARB_STATS_EN
    logic [15:0]      sec0_q, sec0_d, sec1_q, sec1_d;
    logic [7:0]       tos_q, tos_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sd_lba_q <= '0;
            sd_rd_q  <= 1'b0;
            grant_q  <= 2'b00;
            terr_q   <= 1'b0;
            serr_q   <= 1'b0;
            to_cnt   <= '0;
            wcnt     <= '0;
            streak   <= '0;
`ifdef MSU_ARB_STATS_EN
            sec0_q   <= '0;
            sec1_q   <= '0;
            tos_q    <= '0;
`endif
        end else begin
            state    <= state_d;
            sd_lba_q <= sd_lba_d;
            sd_rd_q  <= sd_rd_d;
            grant_q  <= grant_d;
            terr_q   <= terr_d;
            serr_q   <= serr_d;
            to_cnt   <= to_cnt_d;
            wcnt     <= wcnt_d;
            streak   <= streak_d;
`ifdef MSU_ARB_STATS_EN
            sec0_q   <= sec0_d;
            sec1_q   <= sec1_d;
            tos_q    <= tos_d;
`endif
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state;
        sd_lba_d = sd_lba_q;
        sd_rd_d  = sd_rd_q;
        grant_d  = grant_q;
        terr_d   = 1'b0;
        serr_d   = 1'b0;
        to_cnt_d = to_cnt;
        wcnt_d   = wcnt;
        streak_d = streak;
        take0    = 1'b0;
        take1    = 1'b0;
`ifdef MSU_ARB_STATS_EN
        sec0_d   = sec0_q;
        sec1_d   = sec1_q;
        tos_d    = tos_q;
`endif
        case (state)
            IDLE: begin
                // urgent or starved ch0 beats ch1; otherwise ch1 has priority
                if (bus.rd0 && (bus.urgent0 || streak >= ST_W'(STARVE_LIMIT))) take0 = 1'b1;
                else if (bus.rd1) take1 = 1'b1;
                else if (bus.rd0) take0 = 1'b1;

                if (take0) begin
                    sd_lba_d = bus.lba0;
                    grant_d  = 2'b01;
                    streak_d = '0;
                end else if (take1) begin
                    sd_lba_d = bus.lba1;
                    grant_d  = 2'b10;
                    if (bus.rd0 && streak < ST_W'(STARVE_LIMIT)) streak_d = streak + 1'b1;
                end
                if (take0 || take1) begin
                    sd_rd_d  = 1'b1;
                    to_cnt_d = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.sd_ack) begin
                    sd_rd_d = 1'b0;
                    wcnt_d  = '0;
                    state_d = XFER;
                end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    // requester is left un-acked and must re-request
                    sd_rd_d = 1'b0;
                    grant_d = 2'b00;
                    terr_d  = 1'b1;
                    state_d = GAP;
`ifdef MSU_ARB_STATS_EN
                    if (tos_q != 8'hFF) tos_d = tos_q + 1'b1;
`endif
                end else begin
                    to_cnt_d = to_cnt + 1'b1;
                end
            end
            XFER: begin
                if (!bus.sd_ack) begin
                    serr_d  = (wcnt != WC_W'(SECTOR_WORDS));
                    grant_d = 2'b00;
                    state_d = GAP;
`ifdef MSU_ARB_STATS_EN
                    if (grant_q[0]) sec0_d = sec0_q + 1'b1;
                    if (grant_q[1]) sec1_d = sec1_q + 1'b1;
`endif
                end else if (bus.sd_buff_wr && wcnt != '1) begin
                    wcnt_d = wcnt + 1'b1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Forwarded handshake: only the owner sees the HPS strobes, only during XFER
    assign bus.ack0        = (state == XFER) & grant_q[0] & bus.sd_ack;
    assign bus.ack1        = (state == XFER) & grant_q[1] & bus.sd_ack;
    assign bus.wr0         = (state == XFER) & grant_q[0] & bus.sd_buff_wr;
    assign bus.wr1         = (state == XFER) & grant_q[1] & bus.sd_buff_wr;
    assign bus.sd_lba      = sd_lba_q;
    assign bus.sd_rd       = sd_rd_q;
    assign bus.grant       = grant_q;
    assign bus.timeout_err = terr_q;
    assign bus.short_err   = serr_q;
`ifdef MSU_ARB_STATS_EN
    assign bus.sectors0    = sec0_q;
    assign bus.sectors1    = sec1_q;
    assign bus.timeouts    = tos_q;
`endif
endmodule

// File: tb/tb_msu_sd_arbiter.sv
// Directed self-checking bench for msu_sd_arbiter (TIMEOUT_CYCLES shortened to 16).
module tb_msu_sd_arbiter;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    msu_sd_arbiter_if bus ();

    msu_sd_arbiter #(
        .SECTOR_WORDS   (256),
        .TIMEOUT_CYCLES (16),
        .STARVE_LIMIT   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // HPS model: from ISSUE, ack, stream n words, drop ack; returns in the GAP cycle
    task automatic do_sector(input int n, output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        bus.sd_ack = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            bus.sd_buff_wr = 1'b1;
            #1;
            if (bus.wr0) c0++;
            if (bus.wr1) c1++;
            @(posedge clk);
            #1;
        end
        bus.sd_buff_wr = 1'b0;
        bus.sd_ack     = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.rd0 = 1'b1;
        bus.lba0 = 21'h1ABCD;
        tick(); tick();
        tests++; if (bus.grant !== 2'b00) begin fails++; $display("FAIL reset_grant: got %b exp 00", bus.grant); end
        tests++; if (bus.sd_rd !== 1'b0) begin fails++; $display("FAIL reset_sd_rd: got %b exp 0", bus.sd_rd); end
        tests++; if (bus.sd_lba !== 21'h0) begin fails++; $display("FAIL reset_sd_lba: got %h exp 0", bus.sd_lba); end
        tests++; if ({bus.ack0, bus.ack1, bus.wr0, bus.wr1, bus.timeout_err, bus.short_err} !== 6'b0) begin
            fails++; $display("FAIL reset_flags: got %b exp 000000",
                {bus.ack0, bus.ack1, bus.wr0, bus.wr1, bus.timeout_err, bus.short_err});
        end
        bus.rd0 = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int c0;
        int c1;
        c0 = 0;
        c1 = 0;
        bus.rd0 = 1'b1;
        bus.lba0 = 21'h00010;
        tick();
        tests++; if (bus.grant !== 2'b01) begin fails++; $display("FAIL single_grant: got %b exp 01", bus.grant); end
        tests++; if (bus.sd_rd !== 1'b1) begin fails++; $display("FAIL single_sd_rd: got %b exp 1", bus.sd_rd); end
        tests++; if (bus.sd_lba !== 21'h00010) begin fails++; $display("FAIL single_lba: got %h exp 00010", bus.sd_lba); end
        bus.sd_ack = 1'b1;
        tick();
        tests++; if (bus.sd_rd !== 1'b0) begin fails++; $display("FAIL single_rd_drop: got %b exp 0", bus.sd_rd); end
        tests++; if ({bus.ack0, bus.ack1} !== 2'b10) begin fails++; $display("FAIL single_ack_route: got %b exp 10", {bus.ack0, bus.ack1}); end
        bus.rd0 = 1'b0;
        for (int i = 0; i < 256; i++) begin
            bus.sd_buff_wr = 1'b1;
            #1;
            if (bus.wr0) c0++;
            if (bus.wr1) c1++;
            @(posedge clk);
            #1;
        end
        bus.sd_buff_wr = 1'b0;
        bus.sd_ack = 1'b0;
        tests++; if (c0 !== 256) begin fails++; $display("FAIL single_wr0_count: got %0d exp 256", c0); end
        tests++; if (c1 !== 0) begin fails++; $display("FAIL single_wr1_count: got %0d exp 0", c1); end
        tick();
        tests++; if (bus.grant !== 2'b00) begin fails++; $display("FAIL single_gap_grant: got %b exp 00", bus.grant); end
        tests++; if (bus.short_err !== 1'b0) begin fails++; $display("FAIL single_short_err: got %b exp 0", bus.short_err); end
        tick();
        // stray ack while idle must not be forwarded
        bus.sd_ack = 1'b1;
        #1;
        tests++; if ({bus.ack0, bus.ack1} !== 2'b00) begin fails++; $display("FAIL stray_ack: got %b exp 00", {bus.ack0, bus.ack1}); end
        bus.sd_ack = 1'b0;
        tick();
        tests++; if (bus.grant !== 2'b00 || bus.sd_rd !== 1'b0) begin
            fails++; $display("FAIL stray_ack_idle: got grant %b sd_rd %b exp 00 0", bus.grant, bus.sd_rd);
        end
    endtask

    task automatic test_priority();
        int c0;
        int c1;
        bus.rd0 = 1'b1; bus.lba0 = 21'h00111;
        bus.rd1 = 1'b1; bus.lba1 = 21'h00222;
        bus.urgent0 = 1'b0;
        tick();
        tests++; if (bus.grant !== 2'b10) begin fails++; $display("FAIL prio_ch1_first: got %b exp 10", bus.grant); end
        tests++; if (bus.sd_lba !== 21'h00222) begin fails++; $display("FAIL prio_lba1: got %h exp 00222", bus.sd_lba); end
        bus.lba1 = 21'h1FFFF;
        do_sector(256, c0, c1);
        tests++; if (c1 !== 256 || c0 !== 0) begin fails++; $display("FAIL prio_ch1_words: got %0d/%0d exp 0/256", c0, c1); end
        tests++; if (bus.sd_lba !== 21'h00222) begin fails++; $display("FAIL prio_lba_latched: got %h exp 00222", bus.sd_lba); end
        bus.rd1 = 1'b0;
        tick(); tick();
        tests++; if (bus.grant !== 2'b01 || bus.sd_lba !== 21'h00111) begin
            fails++; $display("FAIL prio_ch0_second: got %b %h exp 01 00111", bus.grant, bus.sd_lba);
        end
        do_sector(256, c0, c1);
        bus.rd0 = 1'b0;
        tick();
        bus.rd0 = 1'b1; bus.rd1 = 1'b1; bus.urgent0 = 1'b1;
        tick();
        tests++; if (bus.grant !== 2'b01) begin fails++; $display("FAIL prio_urgent: got %b exp 01", bus.grant); end
        do_sector(256, c0, c1);
        bus.rd0 = 1'b0; bus.urgent0 = 1'b0;
        tick(); tick();
        tests++; if (bus.grant !== 2'b10) begin fails++; $display("FAIL prio_urgent_then_ch1: got %b exp 10", bus.grant); end
        do_sector(256, c0, c1);
        bus.rd1 = 1'b0;
        tick();
    endtask

    task automatic test_starve();
        int c0;
        int c1;
        bus.rd0 = 1'b1; bus.lba0 = 21'h00300;
        bus.rd1 = 1'b1; bus.lba1 = 21'h00400;
        for (int k = 0; k < 5; k++) begin
            tick();
            tests++;
            if (bus.grant !== ((k < 4) ? 2'b10 : 2'b01)) begin
                fails++; $display("FAIL starve_grant_%0d: got %b exp %b", k, bus.grant, (k < 4) ? 2'b10 : 2'b01);
            end
            do_sector(256, c0, c1);
            if (k == 4) begin bus.rd0 = 1'b0; bus.rd1 = 1'b0; end
            tick();
        end
    endtask

    task automatic test_timeout();
        int high;
        int terr;
        int acks;
        high = 0; terr = 0; acks = 0;
        bus.rd0 = 1'b1; bus.lba0 = 21'h00033;
        tick();
        if (bus.sd_rd) high++;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.sd_rd) high++;
            if (bus.ack0) acks++;
            if (bus.timeout_err) begin
                terr++;
                bus.rd0 = 1'b0;
                tests++; if (bus.grant !== 2'b00) begin fails++; $display("FAIL timeout_grant: got %b exp 00", bus.grant); end
            end
        end
        tests++; if (high !== 16) begin fails++; $display("FAIL timeout_rd_cycles: got %0d exp 16", high); end
        tests++; if (terr !== 1) begin fails++; $display("FAIL timeout_pulses: got %0d exp 1", terr); end
        tests++; if (acks !== 0) begin fails++; $display("FAIL timeout_ack0: got %0d exp 0", acks); end
    endtask

    task automatic test_short();
        int c0;
        int c1;
        bus.rd1 = 1'b1; bus.lba1 = 21'h00044;
        tick();
        tests++; if (bus.grant !== 2'b10) begin fails++; $display("FAIL short_grant: got %b exp 10", bus.grant); end
        do_sector(200, c0, c1);
        tests++; if (c1 !== 200 || c0 !== 0) begin fails++; $display("FAIL short_words: got %0d/%0d exp 0/200", c0, c1); end
        tests++; if (bus.short_err !== 1'b1) begin fails++; $display("FAIL short_err_pulse: got %b exp 1", bus.short_err); end
        bus.rd1 = 1'b0;
        tick();
        tests++; if (bus.short_err !== 1'b0) begin fails++; $display("FAIL short_err_one_cycle: got %b exp 0", bus.short_err); end
        bus.rd0 = 1'b1; bus.lba0 = 21'h00045;
        tick();
        tests++; if (bus.grant !== 2'b01) begin fails++; $display("FAIL short_next_grant: got %b exp 01", bus.grant); end
        do_sector(256, c0, c1);
        tests++; if (bus.short_err !== 1'b0 || c0 !== 256) begin
            fails++; $display("FAIL short_next_clean: got err %b words %0d exp 0 256", bus.short_err, c0);
        end
        bus.rd0 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_xfer();
        int c0;
        int c1;
        bus.rd0 = 1'b1; bus.lba0 = 21'h00055;
        tick();
        bus.sd_ack = 1'b1;
        tick();
        for (int i = 0; i < 100; i++) begin
            bus.sd_buff_wr = 1'b1;
            tick();
        end
        bus.sd_buff_wr = 1'b1;
        #1;
        tests++; if (bus.wr0 !== 1'b1) begin fails++; $display("FAIL rstmid_pre_wr0: got %b exp 1", bus.wr0); end
        reset = 1'b0;
        #1;
        tests++; if (bus.sd_rd !== 1'b0 || bus.grant !== 2'b00) begin
            fails++; $display("FAIL rstmid_drop: got sd_rd %b grant %b exp 0 00", bus.sd_rd, bus.grant);
        end
        tests++; if ({bus.wr0, bus.ack0} !== 2'b00) begin fails++; $display("FAIL rstmid_gate: got %b exp 00", {bus.wr0, bus.ack0}); end
        @(posedge clk);
        bus.sd_ack = 1'b0;
        bus.sd_buff_wr = 1'b0;
        bus.lba0 = 21'h00066;
        #2 reset = 1'b1;
        tick();
        tests++; if (bus.grant !== 2'b01 || bus.sd_lba !== 21'h00066) begin
            fails++; $display("FAIL rstmid_regrant: got %b %h exp 01 00066", bus.grant, bus.sd_lba);
        end
        do_sector(256, c0, c1);
        tests++; if (c0 !== 256 || c1 !== 0 || bus.short_err !== 1'b0) begin
            fails++; $display("FAIL rstmid_clean: got %0d/%0d err %b exp 256/0 0", c0, c1, bus.short_err);
        end
        bus.rd0 = 1'b0;
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        bus.rd0 = 1'b0; bus.lba0 = '0; bus.urgent0 = 1'b0;
        bus.rd1 = 1'b0; bus.lba1 = '0;
        bus.sd_ack = 1'b0; bus.sd_buff_wr = 1'b0;
        test_reset();
        test_single();
        test_priority();
        test_starve();
        test_timeout();
        test_short();
        test_reset_mid_xfer();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
